// File: rtl/shift_frame_loader_pkg.sv
// rtl/shift_frame_loader_pkg.sv - shared types and default sizes for the shift frame loader
// Contents:
//   ser_state_t : serialiser FSM state (IDLE, SEND)
//   CH_DEF      : default number of serial input channels
//   W_DEF       : default lane width / frame length in beats
//   DW_DEF      : default compressor result width
package shift_frame_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  localparam int CH_DEF = 12;
  localparam int W_DEF  = 12;
  localparam int DW_DEF = 16;

endpackage

// File: rtl/shift_frame_loader_if.sv
// rtl/shift_frame_loader_if.sv - serial result stream between the loader and its sink
// Signals:
//   dst_ser       : serial result bit, LSB first
//   dst_ser_valid : dst_ser is valid this cycle
//   dst_ready     : sink accepts dst_ser this cycle
//   dst_last      : current bit is the final bit of the result
// Modports:
//   master : driven by the loader
//   slave  : driven by the sink
interface shift_frame_loader_if;

  logic dst_ser;
  logic dst_ser_valid;
  logic dst_ready;
  logic dst_last;

  modport master (
    output dst_ser,
    output dst_ser_valid,
    output dst_last,
    input  dst_ready
  );

  modport slave (
    input  dst_ser,
    input  dst_ser_valid,
    input  dst_last,
    output dst_ready
  );

endinterface

// File: rtl/shift_frame_loader_serializer.sv
// rtl/shift_frame_loader_serializer.sv - captures a compressor result per frame and streams it out LSB first
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous flush of all state
//   frame_valid : a frame completed; capture dst_in at this edge
//   dst_in      : compressor result to capture
//   ready       : sink accepts the current bit
//   ser         : current serial bit
//   ser_valid   : ser is valid
//   last        : current bit is bit DW-1
//   overrun     : sticky, a frame arrived while a transfer was still running
module result_serializer
  import shift_frame_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          frame_valid,
  input  logic [DW-1:0] dst_in,
  input  logic          ready,
  output logic          ser,
  output logic          ser_valid,
  output logic          last,
  output logic          overrun
);

  localparam int IW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DW - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);

  ser_state_t    state;
  logic [DW-1:0] shadow;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic          valid_q;
  logic          last_q;
  logic          ovr_q;
  logic          hs;
  logic          final_beat;

  assign idx_nxt    = idx + IDX_ONE;
  assign hs         = valid_q & ready;
  assign final_beat = hs & (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shadow  <= '0;
      idx     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (clear) begin
      // Flush wins over any frame or handshake landing in the same cycle.
      state   <= IDLE;
      shadow  <= '0;
      idx     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else if (state == IDLE) begin
      if (frame_valid) begin
        state   <= SEND;
        shadow  <= dst_in;
        idx     <= '0;
        valid_q <= 1'b1;
        last_q  <= (DW == 1);
      end
    end else begin
      if (final_beat) begin
        if (frame_valid) begin
          // Next result is ready exactly as the current one drains: chain it
          // with no idle cycle and without flagging an overrun.
          shadow  <= dst_in;
          idx     <= '0;
          last_q  <= (DW == 1);
        end else begin
          state   <= IDLE;
          shadow  <= shadow >> 1;
          idx     <= '0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      end else begin
        if (hs) begin
          shadow <= shadow >> 1;
          idx    <= idx_nxt;
          last_q <= (idx_nxt == LAST_IDX);
        end
        // Busy with an unfinished transfer: the new frame is lost.
        if (frame_valid) begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign ser       = shadow[0];
  assign ser_valid = valid_q;
  assign last      = last_q;
  assign overrun   = ovr_q;

endmodule

// File: rtl/shift_frame_loader.sv
// rtl/shift_frame_loader.sv - shifts CH serial streams into W-bit lanes and serialises the compressor result
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : synchronous flush of all state
//   in_valid    : qualifies src_ this cycle
//   src_        : one serial bit per channel
//   src_frame   : lane c at bits [c*W +: W], to the compressor
//   frame_valid : one-cycle pulse after the W-th accepted beat
//   dst_in      : compressor result, combinational from src_frame
//   overrun     : sticky, a frame was dropped while the serialiser was busy
//   dst         : serial result stream (master side)
module shift_frame_loader
  import shift_frame_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int W  = W_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [CH-1:0]     src_,
  output logic [CH*W-1:0]   src_frame,
  output logic              frame_valid,
  input  logic [DW-1:0]     dst_in,
  output logic              overrun,
  shift_frame_loader_if.master dst
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt;
  logic          fv_q;
  logic          ser_bit;
  logic          ser_valid;
  logic          ser_last;
  logic          ser_ovr;

  // Fill counter: W accepted beats make a frame; the pulse follows the
  // wrapping beat by one cycle so the compressor sees the completed lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      fv_q <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      fv_q <= 1'b0;
    end else begin
      fv_q <= in_valid & (cnt == CNT_LAST);
      if (in_valid) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_lane
    logic [W-1:0] lane;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane <= '0;
      end else if (clear) begin
        lane <= '0;
      end else if (in_valid) begin
        lane <= {lane[W-2:0], src_[c]};
      end
    end

    assign src_frame[c*W +: W] = lane;
  end

  result_serializer #(
    .DW (DW)
  ) u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .frame_valid (fv_q),
    .dst_in      (dst_in),
    .ready       (dst.dst_ready),
    .ser         (ser_bit),
    .ser_valid   (ser_valid),
    .last        (ser_last),
    .overrun     (ser_ovr)
  );

  assign frame_valid       = fv_q;
  assign overrun           = ser_ovr;
  assign dst.dst_ser       = ser_bit;
  assign dst.dst_ser_valid = ser_valid;
  assign dst.dst_last      = ser_last;

endmodule

// File: doc/shift_frame_loader.md
# shift_frame_loader

Parametrised successor to the per-channel serial-input harness in front of the compressor under test. Shifts `CH` serial bit streams into `W`-bit lanes under a valid qualifier, counts bits to flag complete frames, and presents the lanes as one flat vector to the compressor. On each completed frame it captures the compressor's `DW`-bit result and serialises it out LSB-first under a valid/ready handshake, flagging frames dropped while the serialiser is busy.

## Interface
- `CH`, default 12: number of serial input channels.
- `W`, default 12: bits per channel lane; also the frame length in accepted beats.
- `DW`, default 16: width of the compressor result.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous flush of all state.
- `in_valid`  in  1  qualifies `src_` this cycle.
- `src_`  in  CH  one serial bit per channel.
- `src_frame`  out  CH*W  lane `c` at bits `[c*W +: W]`, to the compressor.
- `frame_valid`  out  1  one-cycle pulse when a frame completes.
- `dst_in`  in  DW  compressor result, combinational from `src_frame`.
- `dst_ser`  out  1  serial result bit.
- `dst_ser_valid`  out  1  `dst_ser` is valid.
- `dst_ready`  in  1  sink accepts `dst_ser`.
- `dst_last`  out  1  marks bit `DW-1` of the result.
- `overrun`  out  1  sticky; set when a frame is dropped.

## Operation
- Reset value of every register and output is 0. Serialiser state is IDLE.
- Lane shift: on each edge with `in_valid` and not `clear`, every lane is updated as `lane_c <= {lane_c[W-2:0], src_[c]}`. The oldest bit is discarded. Without `in_valid`, lanes hold.
- Fill counter, `$clog2(W)` bits wide, counts 0..W-1. It increments per accepted beat.
  - A beat at count W-1 wraps the counter to 0 and sets `frame_valid` for the next cycle only.
  - Back-to-back frames are legal. `frame_valid` can pulse every W cycles.
- Serialiser FSM has two states, IDLE and SEND.
  - IDLE to SEND: `frame_valid` is high. At that edge, `dst_in` is captured into a shift register and the bit index is reset to 0.
  - In SEND: `dst_ser_valid` = 1, `dst_ser` = shadow bit 0, and `dst_last` = (index == DW-1).
  - Each beat with `dst_ser_valid` and `dst_ready` shifts the shadow right and increments the index.
  - SEND to IDLE: the handshake completes on the last bit, unless `frame_valid` is high at that same edge. In that case a new capture is taken and the FSM stays in SEND with index 0.
  - `frame_valid` in SEND without the final handshake: the frame is dropped, `overrun` is set, and the current transfer continues unaffected.
- `clear` returns every register to its reset value, including `overrun`.
  - `clear` has priority over `in_valid`, `frame_valid` and handshakes in the same cycle.
  - If `clear` coincides with a `frame_valid` pulse, that frame is discarded.
- Asynchronous reset mid-transfer: all outputs go to 0 immediately. No partial frame is retained.

## Timing
- Let edge k be the edge that accepts the W-th beat of a frame.
  - `src_frame` holds the full frame from edge k.
  - `frame_valid` is high in cycle k..k+1.
  - The capture happens at edge k+1.
  - `dst_ser_valid` rises after edge k+1.
- Result latency with `dst_ready` tied high: bit i is presented in cycle k+1+i, and `dst_last` is presented in cycle k+DW.
- `dst_ser` and `dst_last` must remain stable while `dst_ser_valid` is high and `dst_ready` is low.
- All outputs are registered except `src_frame`, which is driven directly from the lane registers.

## Structure
- Shared package `shift_frame_pkg` holds:
  - the state enum `ser_state_t` (IDLE, SEND);
  - the default constants `CH_DEF`, `W_DEF`, `DW_DEF`.
- Sub-module `result_serializer` holds the FSM, shadow register, index counter, handshake and overrun logic, parametrised by `DW`.
- Lanes and the fill counter stay in the top level as a generate loop.

## Test plan
- Reset, then 12 beats with `src_` = 12'hFFF → after edge 12, `src_frame` = all ones and `frame_valid` pulses exactly once. `overrun` stays 0.
- Channel 3 alternating 1,0,… and other channels 0 for 12 beats → lane 3 = 12'hAAA and every other lane = 0. With `in_valid` gaps inserted, the result is identical and the `frame_valid` pulse is delayed by the gap count.
- Model compressor returns 16'hA5C3 with `dst_ready` = 1 → `dst_ser` = 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles, with `dst_last` on the 16th.
- `dst_ready` held low for 40 cycles while the next frame completes → `overrun` = 1, the first result completes intact after ready returns, and the FSM then goes to IDLE.
- Final handshake in the same cycle as `frame_valid` → the next result starts with no idle cycle and `overrun` stays 0.
- `clear` at beat 7, and separately `rst_n` low mid-transfer → counter, lanes, `dst_ser_valid` and `overrun` are all 0, and the next frame needs a full 12 beats.
